pia_bus_responder: RTL

- Bus-side responder for the CPU wrapper's registered address/data/write-enable bus.
- Implements the Apple-1 style keyboard/display PIA register window at BASE_ADDR..BASE_ADDR+3.
- Accepts keyboard characters through a valid/ready handshake and latches them for the CPU.
- Buffers CPU display writes in a small FIFO drained by the video/terminal side. Drives the CPU's active-low interrupt request.

---
 rtl/pia_bus_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/pia_bus_responder.sv
// Apple-1 style keyboard/display PIA window on the CPU wrapper's registered bus.
// Keyboard characters arrive by valid/ready; display writes queue in a small FWFT FIFO.
module pia_bus_responder #(
    parameter logic [15:0] BASE_ADDR = 16'hD010,
    parameter int          DSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] ab,
    input  logic [7:0]  dbo,
    input  logic        we,
    output logic [7:0]  dbi,
    output logic        sel,
    input  logic        kbd_valid,
    input  logic [6:0]  kbd_data,
    output logic        kbd_ready,
    output logic        dsp_valid,
    output logic [6:0]  dsp_data,
    input  logic        dsp_ready,
    output logic        irq_n
);
    localparam int PW = $clog2(DSP_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DSP_DEPTH);

    logic          kbd_full_reg, kbd_full_next;
    logic [6:0]    kbd_char_reg;
    logic          kbd_ready_reg;
    logic [5:0]    ctl_k_reg, ctl_d_reg;
    logic          ovf_reg, ovf_next;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]   count_reg, count_next;
    logic [7:0]    dbi_reg, read_data;
    logic          irq_n_reg;
    logic [6:0]    mem [DSP_DEPTH];

    logic rd_strobe, wr_strobe, fifo_empty, fifo_full;
    logic pop, push_req, push, overflow, kbd_take;
    logic dbo_bit7_unused;

    assign dbo_bit7_unused = dbo[7];

    assign sel        = (ab[15:2] == BASE_ADDR[15:2]);
    assign rd_strobe  = enable && sel && !we;
    assign wr_strobe  = enable && sel && we;
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_COUNT);
    assign pop        = !fifo_empty && dsp_ready;
    assign push_req   = wr_strobe && (ab[1:0] == 2'd2);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push       = push_req && (!fifo_full || pop);
    assign overflow   = push_req && fifo_full && !pop;
    assign kbd_take   = kbd_valid && kbd_ready_reg;

    always_comb begin
        kbd_full_next = kbd_full_reg;
        if (rd_strobe && ab[1:0] == 2'd0) kbd_full_next = 1'b0;
        if (kbd_take) kbd_full_next = 1'b1;

        // Overflow wins over a same-cycle read clear so no drop goes unreported.
        ovf_next = ovf_reg;
        if (rd_strobe && ab[1:0] == 2'd3) ovf_next = 1'b0;
        if (overflow) ovf_next = 1'b1;

        count_next = count_reg;
        if (push && !pop) count_next = count_reg + 1'b1;
        else if (pop && !push) count_next = count_reg - 1'b1;

        read_data = '0;
        if (sel) begin
            case (ab[1:0])
                2'd0: read_data = {1'b1, kbd_char_reg};
                2'd1: read_data = {kbd_full_reg, 1'b0, ctl_k_reg};
                2'd2: read_data = {fifo_full, 7'b0};
                default: read_data = {!fifo_empty, ovf_reg, ctl_d_reg};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_full_reg  <= 1'b0;
            kbd_char_reg  <= '0;
            kbd_ready_reg <= 1'b0;
            ctl_k_reg     <= '0;
            ctl_d_reg     <= '0;
            ovf_reg       <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            dbi_reg       <= '0;
            irq_n_reg     <= 1'b1;
        end else begin
            kbd_full_reg  <= kbd_full_next;
            kbd_ready_reg <= !kbd_full_next;
            if (kbd_take) kbd_char_reg <= kbd_data;
            if (wr_strobe && ab[1:0] == 2'd1) ctl_k_reg <= dbo[5:0];
            if (wr_strobe && ab[1:0] == 2'd3) ctl_d_reg <= dbo[5:0];
            ovf_reg   <= ovf_next;
            count_reg <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            dbi_reg   <= read_data;
            irq_n_reg <= !((kbd_full_reg && ctl_k_reg[0]) || (fifo_empty && ctl_d_reg[0]));
        end
    end

    // Storage is left unreset; dsp_data is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= dbo[6:0];
    end

    assign dbi       = dbi_reg;
    assign kbd_ready = kbd_ready_reg;
    assign dsp_valid = !fifo_empty;
    assign dsp_data  = fifo_empty ? 7'd0 : mem[rd_ptr_reg];
    assign irq_n     = irq_n_reg;
endmodule
